// File: rtl/frame_writer.sv
// Writer side of the LED-matrix frame RAM: packs a raster pixel stream into
// half-panel RAM words and flags the display once a full frame is stored.
module frame_writer #(
    parameter int COLS   = 64,
    parameter int ROWS   = 32,
    parameter int ADDR_W = 10,
    parameter int PIX_W  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_ena,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 pix_sof,
    input  logic [PIX_W-1:0]     pix_data,
    output logic                 ram_we,
    output logic [1:0]           ram_be,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [2*PIX_W-1:0]   ram_data,
    output logic                 display_ena,
    output logic                 frame_done,
    output logic                 err_sync,
    output logic [7:0]           frame_cnt
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    typedef enum logic {HUNT, WRITE} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept, do_write, last;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;

    assign pix_ready = (state == WRITE) | wr_ena;
    assign accept    = pix_valid & pix_ready;
    // In HUNT only a sof pixel is stored; everything else is dropped.
    assign do_write  = accept & (pix_sof | (state == WRITE));
    // A sof always lands at (0,0), wherever the counters were.
    assign wx        = pix_sof ? '0 : x;
    assign wy        = pix_sof ? '0 : y;
    assign last      = (state == WRITE) && !pix_sof &&
                       (x == XW'(COLS - 1)) && (y == YW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            x           <= '0;
            y           <= '0;
            ram_we      <= 1'b0;
            ram_be      <= 2'b00;
            ram_addr    <= '0;
            ram_data    <= '0;
            display_ena <= 1'b0;
            frame_done  <= 1'b0;
            err_sync    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            ram_we     <= do_write;
            ram_be     <= do_write ? (wy[YW-1] ? 2'b10 : 2'b01) : 2'b00;
            frame_done <= 1'b0;
            err_sync   <= 1'b0;
            if (do_write) begin
                ram_addr <= {wy[YW-2:0], wx};
                ram_data <= {pix_data, pix_data};
                if (last) begin
                    state       <= HUNT;
                    x           <= '0;
                    y           <= '0;
                    frame_done  <= 1'b1;
                    frame_cnt   <= frame_cnt + 8'd1;
                    display_ena <= 1'b1;
                end else begin
                    state    <= WRITE;
                    err_sync <= pix_sof && (state == WRITE);
                    x        <= wx + XW'(1);
                    y        <= (&wx) ? wy + YW'(1) : wy;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_writer.sv
// Randomised bench for frame_writer against a pixel-index reference model
// (small panel geometry so 256 back-to-back frames stay short).
module tb_frame_writer;
    localparam int COLS = 16;
    localparam int ROWS = 8;
    localparam int AW   = 6;
    localparam int PW   = 24;
    localparam int NPIX = COLS * ROWS;
    localparam int HALF = NPIX / 2;

    logic clk = 1'b0, rst = 1'b0, wr_ena = 1'b0, pix_valid = 1'b0, pix_sof = 1'b0;
    logic [PW-1:0]   pix_data = '0;
    logic            pix_ready, ram_we, display_ena, frame_done, err_sync;
    logic [1:0]      ram_be;
    logic [AW-1:0]   ram_addr;
    logic [2*PW-1:0] ram_data;
    logic [7:0]      frame_cnt;

    frame_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
        .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr), .ram_data(ram_data),
        .display_ena(display_ena), .frame_done(frame_done), .err_sync(err_sync),
        .frame_cnt(frame_cnt));

    always #5 clk = ~clk;

    typedef struct packed {
        logic            we;
        logic [1:0]      be;
        logic [AW-1:0]   addr;
        logic [2*PW-1:0] data;
        logic            fd, es, de;
        logic [7:0]      cnt;
        logic            rdy;
    } obs_t;

    obs_t exp_o;
    logic rdy_seen;
    bit   m_in_frame;
    int   m_idx;
    int   checks = 0, errors = 0;

    function automatic obs_t obs();
        return {ram_we, ram_be, ram_addr, ram_data, frame_done, err_sync,
                display_ena, frame_cnt, rdy_seen};
    endfunction

    task automatic m_reset();
        exp_o      = '0;
        m_in_frame = 0;
        m_idx      = 0;
    endtask

    // Reference: a frame is just pixel indices 0..NPIX-1; the upper half-panel
    // holds indices below HALF, the lower half the rest at idx-HALF.
    task automatic m_step();
        bit wr;
        exp_o.rdy = m_in_frame || wr_ena;
        exp_o.we = 0; exp_o.be = 0; exp_o.fd = 0; exp_o.es = 0;
        wr = 0;
        if (pix_valid && exp_o.rdy) begin
            if (pix_sof) begin
                exp_o.es = m_in_frame;
                m_idx = 0; m_in_frame = 1; wr = 1;
            end else if (m_in_frame) wr = 1;
        end
        if (wr) begin
            exp_o.we   = 1;
            exp_o.addr = AW'(m_idx % HALF);
            exp_o.be   = (m_idx < HALF) ? 2'b01 : 2'b10;
            exp_o.data = {pix_data, pix_data};
            m_idx++;
            if (m_idx == NPIX) begin
                m_in_frame = 0;
                exp_o.fd = 1; exp_o.de = 1;
                exp_o.cnt = exp_o.cnt + 8'd1;
            end
        end
    endtask

    // One clock: drive at negedge, advance the model, return just after posedge.
    task automatic cyc(input bit v, input bit s, input logic [PW-1:0] d);
        @(negedge clk);
        pix_valid = v; pix_sof = s; pix_data = d;
        #1 rdy_seen = pix_ready;
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; pix_valid = 0; pix_sof = 0;
        #1 rdy_seen = pix_ready;
        m_reset();
        exp_o.rdy = wr_ena;
        if (obs() !== exp_o) begin errors++; $display("FAIL reset_values got %h want %h", obs(), exp_o); end
        checks++;
        repeat (2) @(negedge clk);
        if ({ram_we, frame_done, display_ena, frame_cnt} !== 11'd0) begin
            errors++; $display("FAIL reset_hold got %b want 0", {ram_we, frame_done, display_ena, frame_cnt});
        end
        checks++;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        wr_ena = 0;
        do_reset();
    endtask

    task automatic test_full_frame();
        wr_ena = 1;
        for (int i = 0; i < NPIX; i++) begin
            cyc(1, i == 0, PW'(i));
            if (obs() !== exp_o) begin errors++; $display("FAIL full_frame px%0d got %h want %h", i, obs(), exp_o); end
            checks++;
            if (i == 0 || i == HALF - 1 || i == HALF) begin
                if (ram_addr !== AW'(i % HALF) || ram_be !== ((i < HALF) ? 2'b01 : 2'b10) ||
                    ram_data[2*PW-1:PW] !== PW'(i) || ram_we !== 1'b1) begin
                    errors++; $display("FAIL half_boundary px%0d got addr %0d be %b data %h", i, ram_addr, ram_be, ram_data);
                end
                checks++;
            end
        end
        if ({frame_done, display_ena, ram_we, frame_cnt} !== {3'b111, 8'd1}) begin
            errors++; $display("FAIL frame_end got %b want 111_00000001", {frame_done, display_ena, ram_we, frame_cnt});
        end
        checks++;
        cyc(0, 0, 0);
        if (frame_done !== 1'b0 || display_ena !== 1'b1) begin
            errors++; $display("FAIL frame_done_pulse got fd %b de %b want 0 1", frame_done, display_ena);
        end
        checks++;
    endtask

    task automatic test_hunt_discard();
        wr_ena = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, PW'($urandom));
            if (obs() !== exp_o || rdy_seen !== 1'b1 || ram_we !== 1'b0) begin
                errors++; $display("FAIL hunt_discard px%0d got %h want %h", i, obs(), exp_o);
            end
            checks++;
        end
        wr_ena = 0;
        cyc(1, 0, PW'($urandom));
        if (rdy_seen !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL hunt_wr_ena_low got rdy %b we %b want 0 0", rdy_seen, ram_we);
        end
        checks++;
    endtask

    task automatic test_midframe_sof();
        logic [7:0] c0;
        int fd_n;
        c0 = frame_cnt; fd_n = 0;
        wr_ena = 1;
        for (int i = 0; i < 100 + NPIX; i++) begin
            cyc(1, i == 0 || i == 100, PW'($urandom));
            if (obs() !== exp_o) begin errors++; $display("FAIL midframe_sof px%0d got %h want %h", i, obs(), exp_o); end
            checks++;
            if (frame_done) fd_n++;
            if (i == 100) begin
                if (err_sync !== 1'b1 || ram_addr !== '0 || ram_be !== 2'b01) begin
                    errors++; $display("FAIL err_sync got es %b addr %0d be %b want 1 0 01", err_sync, ram_addr, ram_be);
                end
                checks++;
            end
        end
        if (fd_n != 1 || frame_cnt !== c0 + 8'd1) begin
            errors++; $display("FAIL restart_count got done %0d cnt %0d want 1 %0d", fd_n, frame_cnt, c0 + 8'd1);
        end
        checks++;
    endtask

    task automatic test_valid_gaps();
        int we_n, n;
        logic [AW-1:0] nxt_addr;
        we_n = 0; n = 0;
        wr_ena = 1;
        cyc(1, 1, PW'($urandom));
        if (ram_we) we_n++;
        wr_ena = 0;  // must not stall the frame already in progress
        while (m_in_frame && n < 5000) begin
            cyc(1'($urandom_range(0, 1)), 0, PW'($urandom));
            if (obs() !== exp_o) begin errors++; $display("FAIL valid_gaps cyc%0d got %h want %h", n, obs(), exp_o); end
            checks++;
            if (ram_we) begin
                nxt_addr = AW'(we_n % HALF);
                if (ram_addr !== nxt_addr) begin
                    errors++; $display("FAIL gap_addr got %0d want %0d", ram_addr, nxt_addr);
                end
                checks++;
                we_n++;
            end
            n++;
        end
        if (we_n != NPIX || m_in_frame) begin
            errors++; $display("FAIL gap_write_count got %0d want %0d", we_n, NPIX);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        wr_ena = 1;
        for (int i = 0; i < 70; i++) cyc(1, i == 0, PW'($urandom));
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            if (obs() !== exp_o || frame_done !== 1'b0 || display_ena !== 1'b0) begin
                errors++; $display("FAIL aborted_frame cyc%0d got %h want %h", i, obs(), exp_o);
            end
            checks++;
        end
        for (int i = 0; i < NPIX; i++) begin
            cyc(1, i == 0, PW'($urandom));
            if (obs() !== exp_o) begin errors++; $display("FAIL post_reset px%0d got %h want %h", i, obs(), exp_o); end
            checks++;
            if (i == NPIX - 2 && display_ena !== 1'b0) begin
                errors++; $display("FAIL display_early got %b want 0", display_ena);
            end
            if (i == NPIX - 2) checks++;
        end
        if (display_ena !== 1'b1 || frame_cnt !== 8'd1) begin
            errors++; $display("FAIL post_reset_done got de %b cnt %0d want 1 1", display_ena, frame_cnt);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        wr_ena = 1;
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                cyc(1, i == 0, PW'($urandom));
                if (obs() !== exp_o) begin
                    errors++; $display("FAIL back_to_back f%0d px%0d got %h want %h", f, i, obs(), exp_o);
                end
                checks++;
            end
            if (display_ena !== 1'b1 || frame_cnt !== 8'(f + 1)) begin
                errors++; $display("FAIL b2b_count f%0d got de %b cnt %0d want 1 %0d", f, display_ena, frame_cnt, 8'(f + 1));
            end
            checks++;
        end
        cyc(0, 0, 0);
        if (frame_cnt !== 8'd0 || display_ena !== 1'b1) begin
            errors++; $display("FAIL cnt_wrap got cnt %0d de %b want 0 1", frame_cnt, display_ena);
        end
        checks++;
    endtask

    initial begin
        m_reset();
        rdy_seen = 0;
        test_reset();
        test_full_frame();
        test_hunt_discard();
        test_midframe_sof();
        test_valid_gaps();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
